// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register for the 5-stage RV32I core: operand forwarding mux,
// load-use hazard detection with single-bubble insertion, and a saturating load-use counter.
package id_ex_pkg;
    typedef enum logic [1:0] {
        NO_FRWD  = 2'd0,
        EX_FRWD  = 2'd1,
        MEM_FRWD = 2'd2
    } forwarding_e;
endpackage

module id_ex_stage
    import id_ex_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_d_i,
    input  logic [XLEN-1:0]   pc_d_i,
    input  logic [4:0]        rs1_d_i,
    input  logic [4:0]        rs2_d_i,
    input  logic              rs1_used_d_i,
    input  logic              rs2_used_d_i,
    input  logic [4:0]        rd_d_i,
    input  logic              rd_wr_ena_d_i,
    input  logic              is_load_d_i,
    input  logic [XLEN-1:0]   imm_d_i,
    input  logic [CTRL_W-1:0] ctrl_d_i,
    input  logic [XLEN-1:0]   rs1_data_i,
    input  logic [XLEN-1:0]   rs2_data_i,
    input  forwarding_e       forwardA_i,
    input  forwarding_e       forwardB_i,
    input  logic [XLEN-1:0]   alu_result_e_i,
    input  logic [XLEN-1:0]   result_m_i,
    input  logic              hold_i,
    input  logic              flush_i,
    output logic              valid_e_o,
    output logic [XLEN-1:0]   pc_e_o,
    output logic [XLEN-1:0]   imm_e_o,
    output logic [XLEN-1:0]   op_a_e_o,
    output logic [XLEN-1:0]   op_b_e_o,
    output logic [4:0]        rd_e_o,
    output logic              rd_wr_ena_e_o,
    output logic              is_load_e_o,
    output logic [CTRL_W-1:0] ctrl_e_o,
    output logic              stall_d_o,
    output logic [CNT_W-1:0]  load_use_cnt_o
);

    function automatic logic [XLEN-1:0] fwd_mux(input forwarding_e sel,
                                                input logic [XLEN-1:0] rf_val,
                                                input logic [XLEN-1:0] ex_val,
                                                input logic [XLEN-1:0] mem_val);
        case (sel)
            EX_FRWD:  return ex_val;
            MEM_FRWD: return mem_val;
            default:  return rf_val;
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
    endfunction

    logic              valid_q, valid_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   imm_q, imm_d;
    logic [XLEN-1:0]   op_a_q, op_a_d;
    logic [XLEN-1:0]   op_b_q, op_b_d;
    logic [4:0]        rd_q, rd_d;
    logic              rd_wr_ena_q, rd_wr_ena_d;
    logic              is_load_q, is_load_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [XLEN-1:0]   op_a_fwd, op_b_fwd;
    logic              rs1_hit, rs2_hit, load_use;

    // D stage: forwarding and hazard detection
    assign op_a_fwd = fwd_mux(forwardA_i, rs1_data_i, alu_result_e_i, result_m_i);
    assign op_b_fwd = fwd_mux(forwardB_i, rs2_data_i, alu_result_e_i, result_m_i);

    assign rs1_hit  = rs1_used_d_i && (rs1_d_i == rd_q);
    assign rs2_hit  = rs2_used_d_i && (rs2_d_i == rd_q);
    assign load_use = valid_d_i && valid_q && is_load_q && rd_wr_ena_q &&
                      (rd_q != 5'd0) && (rs1_hit || rs2_hit);

    assign stall_d_o = hold_i || (load_use && !flush_i);

    always_comb begin
        valid_d     = valid_q;
        pc_d        = pc_q;
        imm_d       = imm_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        rd_d        = rd_q;
        rd_wr_ena_d = rd_wr_ena_q;
        is_load_d   = is_load_q;
        ctrl_d      = ctrl_q;
        cnt_d       = cnt_q;
        if (!hold_i) begin
            if (flush_i || load_use) begin
                // Flush and load-use bubbles are encoded identically; only load-use is counted.
                valid_d     = 1'b0;
                pc_d        = '0;
                imm_d       = '0;
                op_a_d      = '0;
                op_b_d      = '0;
                rd_d        = '0;
                rd_wr_ena_d = 1'b0;
                is_load_d   = 1'b0;
                ctrl_d      = '0;
                if (!flush_i) cnt_d = sat_inc(cnt_q);
            end else begin
                valid_d     = valid_d_i;
                pc_d        = pc_d_i;
                imm_d       = imm_d_i;
                op_a_d      = op_a_fwd;
                op_b_d      = op_b_fwd;
                rd_d        = rd_d_i;
                rd_wr_ena_d = rd_wr_ena_d_i && valid_d_i;
                is_load_d   = is_load_d_i && valid_d_i;
                ctrl_d      = ctrl_d_i;
            end
        end
    end

    // D -> E stage boundary
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q     <= 1'b0;
            pc_q        <= '0;
            imm_q       <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            rd_q        <= '0;
            rd_wr_ena_q <= 1'b0;
            is_load_q   <= 1'b0;
            ctrl_q      <= '0;
            cnt_q       <= '0;
        end else begin
            valid_q     <= valid_d;
            pc_q        <= pc_d;
            imm_q       <= imm_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            rd_q        <= rd_d;
            rd_wr_ena_q <= rd_wr_ena_d;
            is_load_q   <= is_load_d;
            ctrl_q      <= ctrl_d;
            cnt_q       <= cnt_d;
        end
    end

    assign valid_e_o      = valid_q;
    assign pc_e_o         = pc_q;
    assign imm_e_o        = imm_q;
    assign op_a_e_o       = op_a_q;
    assign op_b_e_o       = op_b_q;
    assign rd_e_o         = rd_q;
    assign rd_wr_ena_e_o  = rd_wr_ena_q;
    assign is_load_e_o    = is_load_q;
    assign ctrl_e_o       = ctrl_q;
    assign load_use_cnt_o = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed hazard/forwarding scenarios plus randomized traffic
// compared cycle by cycle against a behavioural model of the E-stage contents.
module tb_id_ex_stage;
    import id_ex_pkg::*;

    localparam int XLEN   = 32;
    localparam int CTRL_W = 16;
    localparam int CNT_W  = 4;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              valid_d_i;
    logic [XLEN-1:0]   pc_d_i;
    logic [4:0]        rs1_d_i, rs2_d_i;
    logic              rs1_used_d_i, rs2_used_d_i;
    logic [4:0]        rd_d_i;
    logic              rd_wr_ena_d_i, is_load_d_i;
    logic [XLEN-1:0]   imm_d_i;
    logic [CTRL_W-1:0] ctrl_d_i;
    logic [XLEN-1:0]   rs1_data_i, rs2_data_i;
    forwarding_e       forwardA_i, forwardB_i;
    logic [XLEN-1:0]   alu_result_e_i, result_m_i;
    logic              hold_i, flush_i;
    logic              valid_e_o;
    logic [XLEN-1:0]   pc_e_o, imm_e_o, op_a_e_o, op_b_e_o;
    logic [4:0]        rd_e_o;
    logic              rd_wr_ena_e_o, is_load_e_o;
    logic [CTRL_W-1:0] ctrl_e_o;
    logic              stall_d_o;
    logic [CNT_W-1:0]  load_use_cnt_o;

    id_ex_stage #(.XLEN(XLEN), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_d_i(valid_d_i), .pc_d_i(pc_d_i),
        .rs1_d_i(rs1_d_i), .rs2_d_i(rs2_d_i), .rs1_used_d_i(rs1_used_d_i),
        .rs2_used_d_i(rs2_used_d_i), .rd_d_i(rd_d_i), .rd_wr_ena_d_i(rd_wr_ena_d_i),
        .is_load_d_i(is_load_d_i), .imm_d_i(imm_d_i), .ctrl_d_i(ctrl_d_i),
        .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .forwardA_i(forwardA_i),
        .forwardB_i(forwardB_i), .alu_result_e_i(alu_result_e_i), .result_m_i(result_m_i),
        .hold_i(hold_i), .flush_i(flush_i), .valid_e_o(valid_e_o), .pc_e_o(pc_e_o),
        .imm_e_o(imm_e_o), .op_a_e_o(op_a_e_o), .op_b_e_o(op_b_e_o), .rd_e_o(rd_e_o),
        .rd_wr_ena_e_o(rd_wr_ena_e_o), .is_load_e_o(is_load_e_o), .ctrl_e_o(ctrl_e_o),
        .stall_d_o(stall_d_o), .load_use_cnt_o(load_use_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Behavioural view of what the E stage should hold.
    typedef struct {
        logic              valid;
        logic [XLEN-1:0]   pc, imm, opa, opb;
        logic [4:0]        rd;
        logic              wr, ld;
        logic [CTRL_W-1:0] ctrl;
        int                cnt;
    } estate_t;

    estate_t m;
    bit      m_known = 0;

    function automatic logic [XLEN-1:0] pick(input forwarding_e f, input logic [XLEN-1:0] rf);
        if (f == EX_FRWD)  return alu_result_e_i;
        if (f == MEM_FRWD) return result_m_i;
        return rf;
    endfunction

    function automatic bit model_hazard();
        bit dep;
        if (!valid_d_i || !m.valid || !m.ld || !m.wr || m.rd == 5'd0) return 0;
        dep = (rs1_used_d_i && rs1_d_i == m.rd) || (rs2_used_d_i && rs2_d_i == m.rd);
        return dep;
    endfunction

    function automatic estate_t model_next();
        estate_t n;
        estate_t bubble;
        bubble = '{valid: 0, pc: 0, imm: 0, opa: 0, opb: 0, rd: 0, wr: 0, ld: 0, ctrl: 0, cnt: m.cnt};
        if (rst_i) begin
            bubble.cnt = 0;
            return bubble;
        end
        if (hold_i) return m;
        if (flush_i) return bubble;
        if (model_hazard()) begin
            bubble.cnt = (m.cnt < CMAX) ? m.cnt + 1 : CMAX;
            return bubble;
        end
        n = '{valid: valid_d_i, pc: pc_d_i, imm: imm_d_i,
              opa: pick(forwardA_i, rs1_data_i), opb: pick(forwardB_i, rs2_data_i),
              rd: rd_d_i, wr: rd_wr_ena_d_i & valid_d_i, ld: is_load_d_i & valid_d_i,
              ctrl: ctrl_d_i, cnt: m.cnt};
        return n;
    endfunction

    // Inputs are driven 1 time unit after a rising edge; tick checks the
    // combinational stall at the falling edge and the registers just after the next rise.
    task automatic tick();
        estate_t nxt;
        @(negedge clk_i);
        if (m_known) check("stall", stall_d_o, hold_i | (model_hazard() & ~flush_i));
        nxt = model_next();
        @(posedge clk_i);
        #1;
        if (rst_i || m_known) begin
            m = nxt;
            m_known = 1;
            check("valid_e", valid_e_o, m.valid);
            check("pc_e", pc_e_o, m.pc);
            check("imm_e", imm_e_o, m.imm);
            check("op_a", op_a_e_o, m.opa);
            check("op_b", op_b_e_o, m.opb);
            check("rd_e", rd_e_o, m.rd);
            check("wr_e", rd_wr_ena_e_o, m.wr);
            check("ld_e", is_load_e_o, m.ld);
            check("ctrl_e", ctrl_e_o, m.ctrl);
            check("cnt", load_use_cnt_o, m.cnt);
        end
    endtask

    task automatic rand_inputs();
        valid_d_i      = ($urandom_range(0, 3) != 0);
        pc_d_i         = $urandom;
        rs1_d_i        = 5'($urandom_range(0, 7));
        rs2_d_i        = 5'($urandom_range(0, 7));
        rs1_used_d_i   = 1'($urandom_range(0, 1));
        rs2_used_d_i   = 1'($urandom_range(0, 1));
        rd_d_i         = 5'($urandom_range(0, 7));
        rd_wr_ena_d_i  = 1'($urandom_range(0, 1));
        is_load_d_i    = 1'($urandom_range(0, 1));
        imm_d_i        = $urandom;
        ctrl_d_i       = 16'($urandom);
        rs1_data_i     = $urandom;
        rs2_data_i     = $urandom;
        forwardA_i     = forwarding_e'($urandom_range(0, 3));
        forwardB_i     = forwarding_e'($urandom_range(0, 3));
        alu_result_e_i = $urandom;
        result_m_i     = $urandom;
        hold_i         = ($urandom_range(0, 7) == 0);
        flush_i        = ($urandom_range(0, 7) == 0);
        rst_i          = ($urandom_range(0, 40) == 0);
    endtask

    task automatic quiet();
        rst_i = 0; hold_i = 0; flush_i = 0;
        forwardA_i = NO_FRWD; forwardB_i = NO_FRWD;
    endtask

    task automatic set_d(input logic v, input logic [4:0] r1, input logic u1,
                         input logic [4:0] r2, input logic u2, input logic [4:0] rd,
                         input logic wr, input logic ld);
        valid_d_i = v; rs1_d_i = r1; rs1_used_d_i = u1; rs2_d_i = r2; rs2_used_d_i = u2;
        rd_d_i = rd; rd_wr_ena_d_i = wr; is_load_d_i = ld;
    endtask

    int cnt_before;

    initial begin
        @(posedge clk_i);
        #1;
        // Reset with random inputs; first edge only establishes a known state.
        rand_inputs(); rst_i = 1; tick();
        rand_inputs(); rst_i = 1; tick();
        rand_inputs(); rst_i = 1; hold_i = 1; tick();
        check("rst_valid", valid_e_o, 0);
        check("rst_cnt", load_use_cnt_o, 0);

        // Forwarding mux
        rand_inputs(); quiet();
        set_d(1, 5'd1, 1, 5'd2, 1, 5'd3, 1, 0);
        rs1_data_i = 32'h11; rs2_data_i = 32'h11; alu_result_e_i = 32'h22; result_m_i = 32'h33;
        tick(); check("opa_no", op_a_e_o, 32'h11);
        forwardA_i = EX_FRWD; forwardB_i = EX_FRWD;
        tick(); check("opa_ex", op_a_e_o, 32'h22); check("opb_ex", op_b_e_o, 32'h22);
        forwardA_i = MEM_FRWD; forwardB_i = MEM_FRWD;
        tick(); check("opa_mem", op_a_e_o, 32'h33); check("opb_mem", op_b_e_o, 32'h33);
        forwardA_i = forwarding_e'(2'd3); forwardB_i = NO_FRWD;
        tick(); check("opa_rsv", op_a_e_o, 32'h11); check("opb_no", op_b_e_o, 32'h11);

        // Load-use: lw x5 then add x6,x5,x7
        quiet(); set_d(1, 5'd0, 0, 5'd0, 0, 5'd5, 1, 1);
        tick();
        set_d(1, 5'd5, 1, 5'd7, 1, 5'd6, 1, 0);
        #1 check("lu_stall", stall_d_o, 1);
        tick();
        check("lu_bubble_v", valid_e_o, 0); check("lu_bubble_wr", rd_wr_ena_e_o, 0);
        check("lu_cnt", load_use_cnt_o, 1);
        forwardA_i = MEM_FRWD; result_m_i = 32'hABCD;
        #1 check("lu_stall_gone", stall_d_o, 0);
        tick();
        check("lu_adv_v", valid_e_o, 1); check("lu_adv_opa", op_a_e_o, 32'hABCD);
        check("lu_adv_rd", rd_e_o, 6); check("lu_cnt_after", load_use_cnt_o, 1);

        // No false stalls
        quiet(); set_d(1, 5'd0, 0, 5'd0, 0, 5'd0, 1, 1); tick();
        set_d(1, 5'd0, 1, 5'd0, 1, 5'd8, 1, 0);
        #1 check("x0_nostall", stall_d_o, 0); tick();
        set_d(1, 5'd0, 0, 5'd0, 0, 5'd5, 1, 1); tick();
        set_d(1, 5'd5, 0, 5'd9, 1, 5'd8, 1, 0);
        #1 check("unused_nostall", stall_d_o, 0); tick();
        set_d(1, 5'd0, 0, 5'd0, 0, 5'd5, 1, 1); tick();
        set_d(0, 5'd5, 1, 5'd5, 1, 5'd8, 1, 0);
        #1 check("inv_nostall", stall_d_o, 0); tick();
        check("nostall_cnt", load_use_cnt_o, 1);

        // Flush vs hold
        quiet(); set_d(1, 5'd1, 1, 5'd2, 1, 5'd9, 1, 0); pc_d_i = 32'h100; tick();
        flush_i = 1; tick();
        check("flush_v", valid_e_o, 0); check("flush_rd", rd_e_o, 0);
        flush_i = 0; tick();
        flush_i = 1; hold_i = 1; pc_d_i = 32'h200;
        #1 check("fh_stall", stall_d_o, 1); tick();
        check("fh_rd", rd_e_o, 9); check("fh_pc", pc_e_o, 32'h100);
        quiet(); set_d(1, 5'd0, 0, 5'd0, 0, 5'd5, 1, 1); tick();
        cnt_before = int'(load_use_cnt_o);
        set_d(1, 5'd5, 1, 5'd7, 1, 5'd6, 1, 0); flush_i = 1;
        #1 check("flu_stall", stall_d_o, 0); tick();
        check("flu_v", valid_e_o, 0); check("flu_cnt", load_use_cnt_o, cnt_before);

        // Counter saturation then mid-run reset
        quiet();
        for (int i = 0; i < 20; i++) begin
            set_d(1, 5'd0, 0, 5'd0, 0, 5'd5, 1, 1); tick();
            set_d(1, 5'd5, 1, 5'd7, 1, 5'd6, 1, 0); tick();
        end
        check("sat_cnt", load_use_cnt_o, CMAX);
        rst_i = 1; tick();
        check("sat_rst_cnt", load_use_cnt_o, 0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            rand_inputs();
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1);
    end

endmodule
